// File: rtl/gru_seq_cell.sv
// -----------------------------------------------------------------------------
// gru_seq_cell
//
// Sequential scalar GRU cell. It consumes a stream of signed fixed-point
// samples x[t] and keeps the hidden state h between samples. A single
// time-shared signed multiplier is sequenced by an FSM, so one sample takes
// eight compute cycles. Nine weights/biases live in an internal register
// file that is written through a simple strobe port while the cell is idle.
//
// Number format: signed Q(DATA_WIDTH-FRACT_WIDTH).FRACT_WIDTH, ONE = 2^FRACT_WIDTH.
// DATA_WIDTH must be at least FRACT_WIDTH+2 so that +/-ONE is representable.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset (highest priority)
//   in_valid   x_in / in_first valid
//   in_ready   high only while idle
//   x_in       input sample x[t]
//   in_first   start of a sequence: the previous hidden state is taken as 0
//   out_valid  h_out valid, held until out_ready
//   out_ready  consumer accepts h_out
//   h_out      newest hidden state h[t]; keeps its value after the handshake
//   wt_we      weight write strobe (honoured only while idle)
//   wt_addr    0..8 = Wz, Wr, Wh, Uz, Ur, Uh, bz, br, bh; larger values ignored
//   wt_data    weight value
// -----------------------------------------------------------------------------
module gru_seq_cell #(
  parameter int DATA_WIDTH  = 8,
  parameter int FRACT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] x_in,
  input  logic                  in_first,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] h_out,
  input  logic                  wt_we,
  input  logic [3:0]            wt_addr,
  input  logic [DATA_WIDTH-1:0] wt_data
);

  // Widths: W1 for (hc - hp), W2 for all additions, PW wide enough for any
  // product or sum before saturation.
  localparam int W1   = DATA_WIDTH + 1;
  localparam int W2   = DATA_WIDTH + 2;
  localparam int PW   = 2 * DATA_WIDTH + 2;
  localparam int ONE  = 1 << FRACT_WIDTH;
  localparam int N_WT = 9;

  localparam logic signed [PW-1:0]         SAT_MAX   = PW'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [PW-1:0]         SAT_MIN   = ~SAT_MAX;
  localparam logic signed [W2-1:0]         ONE_W     = W2'(ONE);
  localparam logic signed [W2-1:0]         HALF_W    = W2'(ONE / 2);
  localparam logic signed [W2-1:0]         ZERO_W    = '0;
  localparam logic signed [DATA_WIDTH-1:0] ONE_D     = DATA_WIDTH'(ONE);
  localparam logic signed [DATA_WIDTH-1:0] NEG_ONE_D = DATA_WIDTH'(-ONE);

  typedef enum logic [3:0] {
    S_IDLE,
    S_MZX,   // Wz*x
    S_MZH,   // Uz*hp, finish z
    S_MRX,   // Wr*x
    S_MRH,   // Ur*hp, finish r
    S_MRHP,  // r*hp
    S_MHX,   // Wh*x
    S_MHH,   // Uh*(r*hp), finish hc
    S_UPD,   // z*(hc-hp), write h
    S_OUT
  } state_t;

  // ---------------------------------------------------------------------------
  // Arithmetic helpers
  // ---------------------------------------------------------------------------
  function automatic logic signed [DATA_WIDTH-1:0] sat_dw(input logic signed [PW-1:0] v);
    logic signed [DATA_WIDTH-1:0] r;
    if (v > SAT_MAX) begin
      r = SAT_MAX[DATA_WIDTH-1:0];
    end else if (v < SAT_MIN) begin
      r = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      r = v[DATA_WIDTH-1:0];
    end
    return r;
  endfunction

  // Three-term sum evaluated exactly at W2 bits, then saturated once.
  function automatic logic signed [DATA_WIDTH-1:0] sum3(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b,
    input logic signed [DATA_WIDTH-1:0] c
  );
    logic signed [W2-1:0] s;
    s = W2'(a) + W2'(b) + W2'(c);
    return sat_dw(PW'(s));
  endfunction

  // Hard sigmoid: clamp((v >>> 2) + ONE/2, 0, ONE).
  function automatic logic signed [DATA_WIDTH-1:0] hsig(input logic signed [DATA_WIDTH-1:0] v);
    logic signed [W2-1:0]         t;
    logic signed [DATA_WIDTH-1:0] r;
    t = W2'(v >>> 2) + HALF_W;
    if (t < ZERO_W) begin
      r = '0;
    end else if (t > ONE_W) begin
      r = ONE_D;
    end else begin
      r = t[DATA_WIDTH-1:0];
    end
    return r;
  endfunction

  // Hard tanh: clamp(v, -ONE, ONE).
  function automatic logic signed [DATA_WIDTH-1:0] htanh(input logic signed [DATA_WIDTH-1:0] v);
    logic signed [DATA_WIDTH-1:0] r;
    if (v > ONE_D) begin
      r = ONE_D;
    end else if (v < NEG_ONE_D) begin
      r = NEG_ONE_D;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                       state_q, state_d;
  logic signed [DATA_WIDTH-1:0] x_q, x_d;
  logic                         first_q, first_d;
  logic signed [DATA_WIDTH-1:0] p_q, p_d;     // W*x partial product
  logic signed [DATA_WIDTH-1:0] z_q, z_d;
  logic signed [DATA_WIDTH-1:0] r_q, r_d;
  logic signed [DATA_WIDTH-1:0] rh_q, rh_d;   // mul(r, hp)
  logic signed [DATA_WIDTH-1:0] hc_q, hc_d;
  logic signed [DATA_WIDTH-1:0] h_q, h_d;

  logic accept;
  logic wt_wr;

  assign accept = in_valid && (state_q == S_IDLE);
  // Writes land only while idle so a sample in flight always sees one weight set.
  assign wt_wr  = wt_we && (state_q == S_IDLE) && (wt_addr <= 4'd8);

  // ---------------------------------------------------------------------------
  // Weight register file
  // ---------------------------------------------------------------------------
  logic signed [DATA_WIDTH-1:0] wt [N_WT];

  genvar gi;
  generate
    for (gi = 0; gi < N_WT; gi++) begin : g_wt
      logic signed [DATA_WIDTH-1:0] w_q, w_d;

      always_comb begin
        w_d = w_q;
        if (wt_wr && (wt_addr == 4'(gi))) begin
          w_d = wt_data;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          w_q <= '0;
        end else begin
          w_q <= w_d;
        end
      end

      assign wt[gi] = w_q;
    end
  endgenerate

  logic signed [DATA_WIDTH-1:0] wz, wr, wh, uz, ur, uh, bz, br, bh;
  assign wz = wt[0];
  assign wr = wt[1];
  assign wh = wt[2];
  assign uz = wt[3];
  assign ur = wt[4];
  assign uh = wt[5];
  assign bz = wt[6];
  assign br = wt[7];
  assign bh = wt[8];

  // ---------------------------------------------------------------------------
  // Shared multiplier
  // ---------------------------------------------------------------------------
  logic signed [DATA_WIDTH-1:0] hp;
  logic signed [W1-1:0]         diff;
  logic signed [DATA_WIDTH-1:0] mul_a;
  logic signed [W1-1:0]         mul_b;
  logic signed [PW-1:0]         mul_prod;
  logic signed [DATA_WIDTH-1:0] mul_res;

  assign hp = first_q ? '0 : h_q;
  // hc - hp needs one extra bit and is fed to the multiplier unsaturated.
  assign diff = W1'(hc_q) - W1'(hp);

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      S_MZX:  begin mul_a = wz; mul_b = W1'(x_q);  end
      S_MZH:  begin mul_a = uz; mul_b = W1'(hp);   end
      S_MRX:  begin mul_a = wr; mul_b = W1'(x_q);  end
      S_MRH:  begin mul_a = ur; mul_b = W1'(hp);   end
      S_MRHP: begin mul_a = r_q; mul_b = W1'(hp);  end
      S_MHX:  begin mul_a = wh; mul_b = W1'(x_q);  end
      S_MHH:  begin mul_a = uh; mul_b = W1'(rh_q); end
      S_UPD:  begin mul_a = z_q; mul_b = diff;     end
      default: begin mul_a = '0; mul_b = '0;       end
    endcase
  end

  // Arithmetic shift floors toward minus infinity before saturation.
  always_comb begin
    mul_prod = PW'(mul_a) * PW'(mul_b);
    mul_res  = sat_dw(mul_prod >>> FRACT_WIDTH);
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    x_d     = x_q;
    first_d = first_q;
    p_d     = p_q;
    z_d     = z_q;
    r_d     = r_q;
    rh_d    = rh_q;
    hc_d    = hc_q;
    h_d     = h_q;

    if (accept) begin
      x_d     = x_in;
      first_d = in_first;
    end

    case (state_q)
      S_MZX, S_MRX, S_MHX: p_d  = mul_res;
      S_MZH:               z_d  = hsig(sum3(p_q, mul_res, bz));
      S_MRH:               r_d  = hsig(sum3(p_q, mul_res, br));
      S_MRHP:              rh_d = mul_res;
      S_MHH:               hc_d = htanh(sum3(p_q, mul_res, bh));
      S_UPD:               h_d  = sum3(hp, mul_res, '0);
      default:             ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_MZX;
      S_MZX:   state_d = S_MZH;
      S_MZH:   state_d = S_MRX;
      S_MRX:   state_d = S_MRH;
      S_MRH:   state_d = S_MRHP;
      S_MRHP:  state_d = S_MHX;
      S_MHX:   state_d = S_MHH;
      S_MHH:   state_d = S_UPD;
      S_UPD:   state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      first_q <= 1'b0;
      p_q     <= '0;
      z_q     <= '0;
      r_q     <= '0;
      rh_q    <= '0;
      hc_q    <= '0;
      h_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      first_q <= first_d;
      p_q     <= p_d;
      z_q     <= z_d;
      r_q     <= r_d;
      rh_q    <= rh_d;
      hc_q    <= hc_d;
      h_q     <= h_d;
    end
  end

  // h_out is the hidden-state register itself, so it holds after the handshake.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_OUT);
  assign h_out     = h_q;

endmodule

// File: tb/tb_gru_seq_cell.sv
// -----------------------------------------------------------------------------
// tb_gru_seq_cell
//
// Self-checking bench for gru_seq_cell. Each accepted sample pushes the value
// predicted by an integer GRU model onto a scoreboard queue; the queue is
// popped and compared when the cell hands out h_out.
// -----------------------------------------------------------------------------
module tb_gru_seq_cell;

  localparam int DW   = 8;
  localparam int FW   = 5;
  localparam int ONE  = 1 << FW;
  localparam int SMAX = (1 << (DW - 1)) - 1;
  localparam int SMIN = -(1 << (DW - 1));

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] x_in;
  logic          in_first;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] h_out;
  logic          wt_we;
  logic [3:0]    wt_addr;
  logic [DW-1:0] wt_data;

  gru_seq_cell #(.DATA_WIDTH(DW), .FRACT_WIDTH(FW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .in_first  (in_first),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .h_out     (h_out),
    .wt_we     (wt_we),
    .wt_addr   (wt_addr),
    .wt_data   (wt_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int sb_q[$];
  int tw[9];
  int th;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int satm(input int v);
    if (v > SMAX) return SMAX;
    if (v < SMIN) return SMIN;
    return v;
  endfunction

  function automatic int mulm(input int a, input int b);
    return satm((a * b) >>> FW);
  endfunction

  function automatic int hsigm(input int v);
    int t;
    t = (v >>> 2) + ONE / 2;
    if (t < 0) return 0;
    if (t > ONE) return ONE;
    return t;
  endfunction

  function automatic int htanhm(input int v);
    if (v > ONE) return ONE;
    if (v < -ONE) return -ONE;
    return v;
  endfunction

  function automatic int model_step(input int x, input int first);
    int hp, z, r, hc;
    hp = (first != 0) ? 0 : th;
    z  = hsigm(satm(mulm(tw[0], x) + mulm(tw[3], hp) + tw[6]));
    r  = hsigm(satm(mulm(tw[1], x) + mulm(tw[4], hp) + tw[7]));
    hc = htanhm(satm(mulm(tw[2], x) + mulm(tw[5], mulm(r, hp)) + tw[8]));
    return satm(hp + mulm(z, hc - hp));
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic wr_wt(input int addr, input int data);
    wt_we   = 1'b1;
    wt_addr = 4'(addr);
    wt_data = 8'(data);
    @(posedge clk);
    #1;
    wt_we = 1'b0;
    if (addr <= 8) tw[addr] = data;
  endtask

  task automatic clr_wt();
    for (int i = 0; i < 9; i++) wr_wt(i, 0);
  endtask

  // One sample: accept, wait for output, optional backpressure, handshake.
  // busy=1 also pokes a weight write and in_valid while the cell computes.
  // wa>=0 issues a weight write on the same edge as the accept.
  task automatic run(input int x, input int first, input int hold, input int busy,
                     input int wa, input int wd);
    int n;
    int held;
    int e;
    chk("in_ready_idle", int'(in_ready), 1);
    in_valid = 1'b1;
    x_in     = 8'(x);
    in_first = 1'(first);
    if (wa >= 0) begin
      wt_we   = 1'b1;
      wt_addr = 4'(wa);
      wt_data = 8'(wd);
    end
    @(posedge clk);
    if (wa >= 0 && wa <= 8) tw[wa] = wd;
    e = model_step(x, first);
    th = e;
    sb_q.push_back(e);
    #1;
    in_valid = 1'b0;
    wt_we    = 1'b0;
    x_in     = 8'h55;
    in_first = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      wt_we = 1'b0;
      if (n == 1) chk("busy_not_ready", int'(in_ready), 0);
      if (busy != 0 && n == 2) begin
        wt_we   = 1'b1;
        wt_addr = 4'd5;
        wt_data = 8'h7f;
      end
      if (busy != 0 && n == 3) begin
        in_valid = 1'b1;
        x_in     = 8'h33;
      end
      if (busy != 0 && n == 5) in_valid = 1'b0;
      if (out_valid) break;
    end
    wt_we    = 1'b0;
    in_valid = 1'b0;
    chk("latency", n, 8);
    if (!out_valid) begin
      void'(sb_q.pop_back());
      return;
    end
    held = int'($signed(h_out));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_h", int'($signed(h_out)), held);
      chk("hold_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 0, 1);
    end else begin
      e = sb_q.pop_front();
      chk("h_out", int'($signed(h_out)), e);
      $display("sample x=%0d first=%0d h_out=%0d expected=%0d", x, first,
               int'($signed(h_out)), e);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("post_valid", int'(out_valid), 0);
    chk("post_in_ready", int'(in_ready), 1);
    chk("post_h_hold", int'($signed(h_out)), held);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, ov, prev_ov, prev_acc, n_ov, xcur, fcur, e, seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    x_in      = '0;
    in_first  = 1'b0;
    out_ready = 1'b0;
    wt_we     = 1'b0;
    wt_addr   = '0;
    wt_data   = '0;
    for (int i = 0; i < 9; i++) tw[i] = 0;
    th = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_h_out", int'($signed(h_out)), 0);

    // Zero weights
    run(8'h40, 1, 0, 0, -1, 0);

    // Recurrence with bh = ONE
    wr_wt(8, 32);
    run(0, 1, 0, 0, -1, 0);
    for (int i = 0; i < 5; i++) run(0, 0, 0, 0, -1, 0);

    // Saturation
    clr_wt();
    wr_wt(2, 127);
    wr_wt(6, 127);
    run(127, 1, 0, 0, -1, 0);

    // Negative output
    wr_wt(2, 0);
    wr_wt(8, -32);
    run(0, 1, 0, 0, -1, 0);

    // Backpressure, writes/in_valid while busy, out-of-range address
    wr_wt(0, 16);  wr_wt(1, -20); wr_wt(2, 40);
    wr_wt(3, -8);  wr_wt(4, 10);  wr_wt(5, 20);
    wr_wt(6, 4);   wr_wt(7, -6);  wr_wt(8, 12);
    run(20, 1, 5, 1, -1, 0);
    run(-30, 0, 0, 0, -1, 0);
    wr_wt(12, 127);
    run(10, 0, 0, 0, -1, 0);

    // Write and accept on the same edge
    run(15, 0, 0, 0, 8, 5);

    // Reset mid-computation
    clr_wt();
    wr_wt(8, 32);
    run(0, 1, 0, 0, -1, 0);
    wr_wt(0, 20);
    wr_wt(5, 40);
    in_valid = 1'b1;
    x_in     = 8'd50;
    in_first = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 9; i++) tw[i] = 0;
    th = 0;
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_h_out", int'($signed(h_out)), 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("midrst_no_output", seen, 0);
    run(25, 0, 0, 0, -1, 0);
    wr_wt(8, 32);
    run(0, 0, 0, 0, -1, 0);

    // Random samples
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 9; i++) wr_wt(i, int'($urandom_range(127, 0)) - 64);
      run(int'($urandom_range(255, 0)) - 128, ($urandom_range(3, 0) == 0) ? 1 : 0,
          0, 0, -1, 0);
    end

    // Throughput: in_valid and out_ready held high
    xcur      = 7;
    fcur      = 1;
    in_valid  = 1'b1;
    x_in      = 8'(xcur);
    in_first  = 1'b1;
    out_ready = 1'b1;
    prev_ov   = 0;
    prev_acc  = -1;
    n_ov      = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      acc = (in_ready && in_valid) ? 1 : 0;
      ov  = out_valid ? 1 : 0;
      if (ov != 0) begin
        n_ov++;
        chk("tp_pulse", prev_ov, 0);
        if (sb_q.size() == 0) begin
          chk("tp_sb_underflow", 0, 1);
        end else begin
          e = sb_q.pop_front();
          chk("tp_h_out", int'($signed(h_out)), e);
          $display("stream h_out=%0d expected=%0d", int'($signed(h_out)), e);
        end
      end
      if (acc != 0) begin
        if (prev_acc >= 0) chk("tp_gap", c - prev_acc, 10);
        prev_acc = c;
        e = model_step(xcur, fcur);
        th = e;
        sb_q.push_back(e);
      end
      prev_ov = ov;
      @(posedge clk);
      #1;
      if (acc != 0) begin
        xcur     = xcur + 13;
        fcur     = 0;
        x_in     = 8'(xcur);
        in_first = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("tp_out_count", n_ov, 4);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 9999;
        chk("tp_drain_h_out", int'($signed(h_out)), e);
        break;
      end
    end
    chk("tp_drain_seen", seen, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
